rvee_lsu: RTL and testbench

Memory stage of the rvee pipeline. It accepts one operation per handshake from execute. ALU results pass straight through; loads and stores run a single-outstanding data-bus transaction. Each completed operation produces one registered writeback beat (rd, rd_we, rd_data) for the writeback stage, or one exception beat (exception, fault_pc, fault_addr, n_cause) for decode and execute.

---
 rtl/rvee_lsu.sv | 260 ++++++++++++++++++++++++++
 tb/tb_rvee_lsu.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvee_lsu.sv
// rvee_lsu: memory stage; ALU results pass straight through and loads/stores
// use one data-bus transaction at a time. Optional macro: RVEE_LSU_STORE_ACK_EN.
module rvee_lsu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic            ex_load,
    input  logic            ex_store,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_addr,
    input  logic [XLEN-1:0] ex_wdata,
    input  logic [4:0]      ex_rd,
    input  logic            ex_rd_we,
    output logic            dbus_req,
    output logic            dbus_we,
    output logic [XLEN-1:0] dbus_addr,
    output logic [3:0]      dbus_be,
    output logic [XLEN-1:0] dbus_wdata,
    input  logic            dbus_gnt,
    input  logic            dbus_rvalid,
    input  logic [XLEN-1:0] dbus_rdata,
    input  logic            dbus_err,
    output logic [4:0]      rd,
    output logic            rd_we,
    output logic [XLEN-1:0] rd_data,
    output logic            exception,
    output logic [XLEN-1:0] fault_pc,
    output logic [XLEN-1:0] fault_addr,
    output logic [XLEN-2:0] n_cause
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [XLEN-2:0] CAUSE_LD_MISAL = (XLEN-1)'(4);
    localparam logic [XLEN-2:0] CAUSE_LD_FAULT = (XLEN-1)'(5);
    localparam logic [XLEN-2:0] CAUSE_ST_MISAL = (XLEN-1)'(6);
    localparam logic [XLEN-2:0] CAUSE_ST_FAULT = (XLEN-1)'(7);

    logic [1:0]      state_q, state_d;
    logic            ex_ready_q, ex_ready_d;

    logic            op_store_q, op_store_d;
    logic [2:0]      op_funct3_q, op_funct3_d;
    logic [XLEN-1:0] op_pc_q, op_pc_d;
    logic [XLEN-1:0] op_addr_q, op_addr_d;
    logic [4:0]      op_rd_q, op_rd_d;
    logic            op_rd_we_q, op_rd_we_d;

    logic            dbus_req_q, dbus_req_d;
    logic            dbus_we_q, dbus_we_d;
    logic [XLEN-1:0] dbus_addr_q, dbus_addr_d;
    logic [3:0]      dbus_be_q, dbus_be_d;
    logic [XLEN-1:0] dbus_wdata_q, dbus_wdata_d;

    logic [4:0]      rd_q, rd_d;
    logic            rd_we_q, rd_we_d;
    logic [XLEN-1:0] rd_data_q, rd_data_d;
    logic            exception_q, exception_d;
    logic [XLEN-1:0] fault_pc_q, fault_pc_d;
    logic [XLEN-1:0] fault_addr_q, fault_addr_d;
    logic [XLEN-2:0] n_cause_q, n_cause_d;

    logic            accept;
    logic            is_mem;
    logic            misal;
    logic [3:0]      st_be;
    logic [XLEN-1:0] st_wdata;
    logic [XLEN-1:0] ld_shift;
    logic [XLEN-1:0] ld_data;

    assign accept = ex_valid & ex_ready_q;
    assign is_mem = ex_load | ex_store;

    // Decode the incoming op: alignment, store byte enables and lane data
    always_comb begin
        misal    = 1'b0;
        st_be    = 4'b1111;
        st_wdata = ex_wdata;
        case (ex_funct3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << ex_addr[1:0];
                st_wdata = {4{ex_wdata[7:0]}};
            end
            2'b01: begin
                misal    = ex_addr[0];
                st_be    = 4'b0011 << ex_addr[1:0];
                st_wdata = {2{ex_wdata[15:0]}};
            end
            default: begin
                misal    = (ex_addr[1:0] != 2'b00);
            end
        endcase
    end

    // Align the returned word and extend it according to the load width
    always_comb begin
        ld_shift = dbus_rdata >> {op_addr_q[1:0], 3'b000};
        case (op_funct3_q)
            3'b000:  ld_data = {{(XLEN-8){ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_data = {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_shift[7:0]};
            3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_shift[15:0]};
            default: ld_data = ld_shift;
        endcase
    end

    // Sequencing of accept, bus request, response and the result beats
    always_comb begin
        state_d      = state_q;
        op_store_d   = op_store_q;
        op_funct3_d  = op_funct3_q;
        op_pc_d      = op_pc_q;
        op_addr_d    = op_addr_q;
        op_rd_d      = op_rd_q;
        op_rd_we_d   = op_rd_we_q;
        dbus_req_d   = dbus_req_q;
        dbus_we_d    = dbus_we_q;
        dbus_addr_d  = dbus_addr_q;
        dbus_be_d    = dbus_be_q;
        dbus_wdata_d = dbus_wdata_q;
        rd_d         = rd_q;
        rd_we_d      = 1'b0;
        rd_data_d    = rd_data_q;
        exception_d  = 1'b0;
        fault_pc_d   = fault_pc_q;
        fault_addr_d = fault_addr_q;
        n_cause_d    = n_cause_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_store_d  = ex_store;
                    op_funct3_d = ex_funct3;
                    op_pc_d     = ex_pc;
                    op_addr_d   = ex_addr;
                    op_rd_d     = ex_rd;
                    op_rd_we_d  = ex_rd_we;
                    if (!is_mem) begin
                        rd_d      = ex_rd;
                        rd_we_d   = ex_rd_we & (ex_rd != 5'd0);
                        rd_data_d = ex_wdata;
                    end else if (misal) begin
                        exception_d  = 1'b1;
                        fault_pc_d   = ex_pc;
                        fault_addr_d = ex_addr;
                        n_cause_d    = ex_store ? CAUSE_ST_MISAL
                                                : CAUSE_LD_MISAL;
                    end else begin
                        state_d      = S_REQ;
                        dbus_req_d   = 1'b1;
                        dbus_we_d    = ex_store;
                        dbus_addr_d  = {ex_addr[XLEN-1:2], 2'b00};
                        // loads fetch the whole word; enables qualify stores
                        dbus_be_d    = ex_store ? st_be : 4'b0000;
                        dbus_wdata_d = st_wdata;
                    end
                end
            end
            S_REQ: begin
                if (dbus_gnt) begin
                    dbus_req_d = 1'b0;
`ifdef RVEE_LSU_STORE_ACK_EN
                    state_d    = S_RESP;
`else
                    state_d    = op_store_q ? S_IDLE : S_RESP;
`endif
                end
            end
            S_RESP: begin
                if (dbus_rvalid) begin
                    state_d = S_IDLE;
                    if (dbus_err) begin
                        exception_d  = 1'b1;
                        fault_pc_d   = op_pc_q;
                        fault_addr_d = op_addr_q;
                        n_cause_d    = op_store_q ? CAUSE_ST_FAULT
                                                  : CAUSE_LD_FAULT;
                    end else if (!op_store_q) begin
                        rd_d      = op_rd_q;
                        rd_we_d   = op_rd_we_q & (op_rd_q != 5'd0);
                        rd_data_d = ld_data;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ex_ready_d = (state_d == S_IDLE);
    end

    // State registers; reset drops any in-flight transaction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            ex_ready_q   <= 1'b1;
            op_store_q   <= 1'b0;
            op_funct3_q  <= 3'd0;
            op_pc_q      <= '0;
            op_addr_q    <= '0;
            op_rd_q      <= 5'd0;
            op_rd_we_q   <= 1'b0;
            dbus_req_q   <= 1'b0;
            dbus_we_q    <= 1'b0;
            dbus_addr_q  <= '0;
            dbus_be_q    <= 4'd0;
            dbus_wdata_q <= '0;
            rd_q         <= 5'd0;
            rd_we_q      <= 1'b0;
            rd_data_q    <= '0;
            exception_q  <= 1'b0;
            fault_pc_q   <= '0;
            fault_addr_q <= '0;
            n_cause_q    <= '0;
        end else begin
            state_q      <= state_d;
            ex_ready_q   <= ex_ready_d;
            op_store_q   <= op_store_d;
            op_funct3_q  <= op_funct3_d;
            op_pc_q      <= op_pc_d;
            op_addr_q    <= op_addr_d;
            op_rd_q      <= op_rd_d;
            op_rd_we_q   <= op_rd_we_d;
            dbus_req_q   <= dbus_req_d;
            dbus_we_q    <= dbus_we_d;
            dbus_addr_q  <= dbus_addr_d;
            dbus_be_q    <= dbus_be_d;
            dbus_wdata_q <= dbus_wdata_d;
            rd_q         <= rd_d;
            rd_we_q      <= rd_we_d;
            rd_data_q    <= rd_data_d;
            exception_q  <= exception_d;
            fault_pc_q   <= fault_pc_d;
            fault_addr_q <= fault_addr_d;
            n_cause_q    <= n_cause_d;
        end
    end

    assign ex_ready   = ex_ready_q;
    assign dbus_req   = dbus_req_q;
    assign dbus_we    = dbus_we_q;
    assign dbus_addr  = dbus_addr_q;
    assign dbus_be    = dbus_be_q;
    assign dbus_wdata = dbus_wdata_q;
    assign rd         = rd_q;
    assign rd_we      = rd_we_q;
    assign rd_data    = rd_data_q;
    assign exception  = exception_q;
    assign fault_pc   = fault_pc_q;
    assign fault_addr = fault_addr_q;
    assign n_cause    = n_cause_q;

endmodule

// File: tb/tb_rvee_lsu.sv
// tb_rvee_lsu: directed table, hand sequences and randomized ops
// checked against a behavioural model of the memory stage.
module tb_rvee_lsu;

`ifdef RVEE_LSU_STORE_ACK_EN
    localparam bit STORE_ACK = 1'b1;
`else
    localparam bit STORE_ACK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic        ex_load = 1'b0;
    logic        ex_store = 1'b0;
    logic [2:0]  ex_funct3 = 3'd0;
    logic [31:0] ex_pc = '0;
    logic [31:0] ex_addr = '0;
    logic [31:0] ex_wdata = '0;
    logic [4:0]  ex_rd = '0;
    logic        ex_rd_we = 1'b0;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        dbus_gnt = 1'b0;
    logic        dbus_rvalid = 1'b0;
    logic [31:0] dbus_rdata = '0;
    logic        dbus_err = 1'b0;
    logic [4:0]  rd;
    logic        rd_we;
    logic [31:0] rd_data;
    logic        exception;
    logic [31:0] fault_pc;
    logic [31:0] fault_addr;
    logic [30:0] n_cause;

    always #5 clk = ~clk;

    rvee_lsu dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_load(ex_load), .ex_store(ex_store),
        .ex_funct3(ex_funct3), .ex_pc(ex_pc),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .ex_rd(ex_rd), .ex_rd_we(ex_rd_we),
        .dbus_req(dbus_req), .dbus_we(dbus_we),
        .dbus_addr(dbus_addr), .dbus_be(dbus_be),
        .dbus_wdata(dbus_wdata), .dbus_gnt(dbus_gnt),
        .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
        .dbus_err(dbus_err),
        .rd(rd), .rd_we(rd_we), .rd_data(rd_data),
        .exception(exception), .fault_pc(fault_pc),
        .fault_addr(fault_addr), .n_cause(n_cause)
    );

    typedef struct {
        bit          ld, st;
        logic [2:0]  f3;
        logic [31:0] pc, addr, wdata;
        logic [4:0]  rd;
        bit          rdwe;
        int          gd, rdl;
        logic [31:0] rdata;
        bit          err;
    } op_t;

    typedef struct {
        int          seen_req, req_cyc, wb, exc;
        int          beat_cyc, ready_cyc, both, timeout;
        logic        stable, we;
        logic [31:0] addr, wdata, rd_data, fpc, faddr;
        logic [3:0]  be;
        logic [4:0]  rd;
        logic [30:0] cause;
    } res_t;

    typedef struct {
        op_t         o;
        int          e_wb;
        logic [31:0] e_rdd;
        int          e_exc;
        logic [30:0] e_cause;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic op_t mk(bit ld, bit st, logic [2:0] f3,
                               logic [31:0] addr, logic [31:0] wdata,
                               logic [4:0] rdn, bit rdwe, int gd, int rdl,
                               logic [31:0] rdata, bit err);
        op_t o;
        o.ld = ld; o.st = st; o.f3 = f3; o.pc = 32'h0;
        o.addr = addr; o.wdata = wdata; o.rd = rdn; o.rdwe = rdwe;
        o.gd = gd; o.rdl = rdl; o.rdata = rdata; o.err = err;
        return o;
    endfunction

    // Reference: what the stage should do, in cycles after the accept edge
    function automatic res_t model(input op_t o);
        res_t e;
        int off, sz, done;
        logic [31:0] v;
        e = '{default:0};
        e.beat_cyc = -1;
        e.stable = 1'b1;
        off = int'(o.addr % 32'd4);
        sz = o.f3[1] ? 4 : (o.f3[0] ? 2 : 1);
        done = o.gd + o.rdl + 3;
        if (!o.ld && !o.st) begin
            e.ready_cyc = 1;
            if (o.rdwe && o.rd != 0) begin
                e.wb = 1; e.rd = o.rd; e.rd_data = o.wdata; e.beat_cyc = 1;
            end
        end else if (o.addr % 32'(sz) != 0) begin
            e.ready_cyc = 1; e.exc = 1; e.beat_cyc = 1;
            e.cause = o.ld ? 31'd4 : 31'd6;
            e.fpc = o.pc; e.faddr = o.addr;
        end else begin
            e.seen_req = 1;
            e.req_cyc = o.gd + 1;
            e.addr = o.addr - 32'(off);
            e.we = o.st;
            e.be = o.st ? 4'(((1 << sz) - 1) << off) : 4'h0;
            if (sz == 1) e.wdata = {24'd0, o.wdata[7:0]} * 32'h01010101;
            else if (sz == 2) e.wdata = {16'd0, o.wdata[15:0]} * 32'h00010001;
            else e.wdata = o.wdata;
            if (o.ld) begin
                e.ready_cyc = done;
                if (o.err) begin
                    e.exc = 1; e.cause = 31'd5; e.beat_cyc = done;
                    e.fpc = o.pc; e.faddr = o.addr;
                end else if (o.rdwe && o.rd != 0) begin
                    v = o.rdata >> (8 * off);
                    if (sz == 1) begin
                        v = v & 32'hFF;
                        if (!o.f3[2] && v >= 32'd128) v = v + 32'hFFFFFF00;
                    end else if (sz == 2) begin
                        v = v & 32'hFFFF;
                        if (!o.f3[2] && v >= 32'd32768) v = v + 32'hFFFF0000;
                    end
                    e.wb = 1; e.rd = o.rd; e.rd_data = v; e.beat_cyc = done;
                end
            end else if (STORE_ACK) begin
                e.ready_cyc = done;
                if (o.err) begin
                    e.exc = 1; e.cause = 31'd7; e.beat_cyc = done;
                    e.fpc = o.pc; e.faddr = o.addr;
                end
            end else begin
                e.ready_cyc = o.gd + 2;
            end
        end
        return e;
    endfunction

    // Issue one op, act as the bus, and record what the DUT did
    task automatic run_op(input op_t o, output res_t r);
        int rc;
        bit granted, delivered, fin;
        r = '{default:0};
        r.beat_cyc = -1; r.ready_cyc = -1; r.stable = 1'b1;
        rc = 0; granted = 0; delivered = 0; fin = 0;
        @(negedge clk);
        for (int i = 0; i < 50 && !ex_ready; i++) @(negedge clk);
        if (!ex_ready) begin
            r.timeout = 1;
            return;
        end
        ex_valid = 1'b1; ex_load = o.ld; ex_store = o.st;
        ex_funct3 = o.f3; ex_pc = o.pc; ex_addr = o.addr;
        ex_wdata = o.wdata; ex_rd = o.rd; ex_rd_we = o.rdwe;
        @(posedge clk);
        #1;
        ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
        for (int cyc = 1; cyc <= 60 && !fin; cyc++) begin
            @(negedge clk);
            if (rd_we && exception) r.both = 1;
            if (rd_we) begin
                r.wb++; r.rd = rd; r.rd_data = rd_data; r.beat_cyc = cyc;
            end
            if (exception) begin
                r.exc++; r.cause = n_cause; r.fpc = fault_pc;
                r.faddr = fault_addr; r.beat_cyc = cyc;
            end
            if (dbus_req) begin
                if (r.seen_req == 0) begin
                    r.addr = dbus_addr; r.be = dbus_be;
                    r.wdata = dbus_wdata; r.we = dbus_we;
                end else if (dbus_addr !== r.addr || dbus_be !== r.be ||
                             dbus_wdata !== r.wdata || dbus_we !== r.we) begin
                    r.stable = 1'b0;
                end
                r.seen_req = 1;
                r.req_cyc++;
            end
            if (ex_ready && !dbus_req && r.ready_cyc < 0) r.ready_cyc = cyc;
            dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_err = 1'b0;
            if (r.ready_cyc >= 0 && (!granted || delivered)) begin
                fin = 1;
            end else begin
                if (granted && !delivered) begin
                    rc++;
                    if (rc == o.rdl + 1) begin
                        dbus_rvalid = 1'b1; dbus_rdata = o.rdata;
                        dbus_err = o.err; delivered = 1;
                    end
                end
                if (dbus_req && !granted && r.req_cyc == o.gd + 1) begin
                    dbus_gnt = 1'b1; granted = 1;
                end
            end
        end
        if (!fin) r.timeout = 1;
        dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_err = 1'b0;
    endtask

    task automatic compare(input string t, input res_t a, input res_t e,
                           input bit is_st);
        chk({t, " timeout"}, a.timeout, 0);
        chk({t, " rd_we&exc"}, a.both, 0);
        chk({t, " req_seen"}, a.seen_req, e.seen_req);
        chk({t, " ready_cyc"}, a.ready_cyc, e.ready_cyc);
        chk({t, " wb_count"}, a.wb, e.wb);
        chk({t, " exc_count"}, a.exc, e.exc);
        if (e.seen_req != 0) begin
            chk({t, " dbus_addr"}, a.addr, e.addr);
            chk({t, " dbus_be"}, a.be, e.be);
            chk({t, " dbus_we"}, a.we, e.we);
            chk({t, " req_stable"}, a.stable, 1);
            chk({t, " req_cycles"}, a.req_cyc, e.req_cyc);
            if (is_st) chk({t, " dbus_wdata"}, a.wdata, e.wdata);
        end
        if (e.wb != 0) begin
            chk({t, " rd"}, a.rd, e.rd);
            chk({t, " rd_data"}, a.rd_data, e.rd_data);
            chk({t, " wb_cyc"}, a.beat_cyc, e.beat_cyc);
        end
        if (e.exc != 0) begin
            chk({t, " n_cause"}, a.cause, e.cause);
            chk({t, " fault_pc"}, a.fpc, e.fpc);
            chk({t, " fault_addr"}, a.faddr, e.faddr);
            chk({t, " exc_cyc"}, a.beat_cyc, e.beat_cyc);
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        res_t r, e;
        op_t  o;
        int   kind, sz;
        logic [2:0] ldf[5];
        ldf[0] = 3'b000; ldf[1] = 3'b001; ldf[2] = 3'b010;
        ldf[3] = 3'b100; ldf[4] = 3'b101;

        // reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst dbus_req", dbus_req, 0);
        chk("rst dbus_we", dbus_we, 0);
        chk("rst rd_we", rd_we, 0);
        chk("rst exception", exception, 0);
        chk("rst ex_ready", ex_ready, 1);
        chk("rst rd_data", rd_data, 0);
        chk("rst n_cause", n_cause, 0);
        chk("rst dbus_addr", dbus_addr, 0);
        @(negedge clk);
        rst = 1'b1;

        // directed table
        tbl.push_back('{mk(0,0,3'b000,32'h0,32'h1234,5'd5,1,0,0,0,0),
                        1,32'h00001234,0,0,4'h0,0});
        tbl.push_back('{mk(0,0,3'b000,32'h0,32'h1234,5'd0,1,0,0,0,0),
                        0,0,0,0,4'h0,0});
        tbl.push_back('{mk(1,0,3'b000,32'h1003,0,5'd3,1,0,0,32'h80FFFFFF,0),
                        1,32'hFFFFFF80,0,0,4'h0,0});
        tbl.push_back('{mk(1,0,3'b100,32'h1003,0,5'd3,1,0,0,32'h80FFFFFF,0),
                        1,32'h00000080,0,0,4'h0,0});
        tbl.push_back('{mk(0,1,3'b001,32'h2002,32'hAABBCCDD,5'd0,0,2,0,0,0),
                        0,0,0,0,4'hC,32'hCCDDCCDD});
        tbl.push_back('{mk(1,0,3'b010,32'h3001,0,5'd4,1,0,0,0,0),
                        0,0,1,31'd4,4'h0,0});
        tbl.push_back('{mk(1,0,3'b010,32'h3000,0,5'd7,1,1,1,32'hDEAD,1),
                        0,0,1,31'd5,4'h0,0});
        tbl.push_back('{mk(0,1,3'b010,32'h3004,32'h55,5'd0,0,0,0,0,1),
                        0,0,STORE_ACK ? 1 : 0,31'd7,4'hF,32'h55});
        tbl.push_back('{mk(0,1,3'b001,32'h2001,32'h77,5'd0,0,0,0,0,0),
                        0,0,1,31'd6,4'h0,0});
        tbl.push_back('{mk(1,0,3'b001,32'h1002,0,5'd9,1,0,1,32'h80011234,0),
                        1,32'hFFFF8001,0,0,4'h0,0});
        tbl.push_back('{mk(1,0,3'b101,32'h1002,0,5'd9,1,1,0,32'h80011234,0),
                        1,32'h00008001,0,0,4'h0,0});
        tbl.push_back('{mk(0,1,3'b000,32'h1001,32'h12345678,5'd0,0,1,1,0,0),
                        0,0,0,0,4'h2,32'h78787878});
        tbl.push_back('{mk(1,0,3'b010,32'h1004,0,5'd31,1,3,2,32'hCAFEBABE,0),
                        1,32'hCAFEBABE,0,0,4'h0,0});

        foreach (tbl[i]) begin
            string t;
            t = $sformatf("vec%0d", i);
            o = tbl[i].o;
            o.pc = 32'h100 + 32'(i * 4);
            run_op(o, r);
            e = model(o);
            compare(t, r, e, o.st);
            chk({t, " tbl_wb"}, r.wb, tbl[i].e_wb);
            chk({t, " tbl_exc"}, r.exc, tbl[i].e_exc);
            if (tbl[i].e_wb != 0) chk({t, " tbl_rd_data"}, r.rd_data, tbl[i].e_rdd);
            if (tbl[i].e_exc != 0) chk({t, " tbl_cause"}, r.cause, tbl[i].e_cause);
            if (e.seen_req != 0) chk({t, " tbl_be"}, r.be, tbl[i].e_be);
            if (e.seen_req != 0 && o.st) chk({t, " tbl_wdata"}, r.wdata, tbl[i].e_wd);
        end

        // back-to-back pass-through, one op per cycle
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            ex_valid = 1'b1; ex_load = 1'b0; ex_store = 1'b0;
            ex_rd = 5'(k + 1); ex_rd_we = 1'b1; ex_wdata = 32'hA0 + 32'(k);
            @(negedge clk);
            chk($sformatf("b2b%0d ready", k), ex_ready, 1);
            chk($sformatf("b2b%0d rd_we", k), rd_we, 1);
            chk($sformatf("b2b%0d rd", k), rd, 5'(k + 1));
            chk($sformatf("b2b%0d rd_data", k), rd_data, 32'hA0 + 32'(k));
        end
        ex_valid = 1'b0;

        // reset in RESP, then a stale response
        @(negedge clk);
        ex_valid = 1'b1; ex_load = 1'b1; ex_funct3 = 3'b010;
        ex_addr = 32'h4000; ex_pc = 32'h400; ex_rd = 5'd6; ex_rd_we = 1'b1;
        @(posedge clk);
        #1;
        ex_valid = 1'b0; ex_load = 1'b0;
        @(negedge clk);
        chk("rstseq req", dbus_req, 1);
        dbus_gnt = 1'b1;
        @(negedge clk);
        dbus_gnt = 1'b0;
        chk("rstseq req_drop", dbus_req, 0);
        chk("rstseq busy", ex_ready, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("rstseq dbus_addr", dbus_addr, 0);
        chk("rstseq rd_data", rd_data, 0);
        chk("rstseq fault_pc", fault_pc, 0);
        chk("rstseq dbus_be", dbus_be, 0);
        chk("rstseq ex_ready", ex_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        dbus_rvalid = 1'b1; dbus_rdata = 32'h12345678; dbus_err = 1'b1;
        @(negedge clk);
        dbus_rvalid = 1'b0; dbus_err = 1'b0;
        chk("stale rd_we", rd_we, 0);
        chk("stale exception", exception, 0);
        chk("stale ready", ex_ready, 1);
        o = mk(1,0,3'b010,32'h4000,0,5'd6,1,0,0,32'h0BADF00D,0);
        o.pc = 32'h404;
        run_op(o, r);
        compare("post_rst_lw", r, model(o), 1'b0);

        // randomized ops against the model
        for (int n = 0; n < 250; n++) begin
            kind = $urandom_range(0, 2);
            o.ld = (kind == 1); o.st = (kind == 2);
            o.f3 = (kind == 2) ? ldf[$urandom_range(0, 2)]
                               : ldf[$urandom_range(0, 4)];
            sz = o.f3[1] ? 4 : (o.f3[0] ? 2 : 1);
            o.addr = $urandom;
            if ($urandom_range(0, 3) != 0) o.addr = o.addr - (o.addr % 32'(sz));
            o.pc = $urandom & 32'hFFFFFFFC;
            o.wdata = $urandom; o.rdata = $urandom;
            o.rd = 5'($urandom_range(0, 31)); o.rdwe = 1'($urandom_range(0, 1));
            o.gd = $urandom_range(0, 3); o.rdl = $urandom_range(0, 3);
            o.err = ($urandom_range(0, 7) == 0);
            run_op(o, r);
            compare($sformatf("rnd%0d", n), r, model(o), o.st);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
